// File: rtl/pixel_dispatcher.sv
// rtl/pixel_dispatcher.sv - raster-scan initiator that issues pixels to a depth engine and streams (x, y, depth) results
module pixel_dispatcher #(
    parameter int FRAC   = 8,
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480
) (
    input  logic        sysclk,
    input  logic        reset_n,
    input  logic        frame_start,
    input  logic [7:0]  max_iter,
    input  logic [15:0] re_origin,
    input  logic [15:0] im_origin,
    input  logic [15:0] step,
    output logic        eng_start,
    output logic [9:0]  eng_x,
    output logic [8:0]  eng_y,
    output logic [15:0] eng_re_c,
    output logic [15:0] eng_im_c,
    output logic [7:0]  eng_max_iter,
    input  logic        eng_done,
    input  logic [7:0]  eng_depth,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [7:0]  pix_depth,
    output logic        pix_last,
    output logic        busy,
    output logic        frame_done
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUTPUT} state_t;

    state_t      state, state_nxt;
    logic [9:0]  x;
    logic [8:0]  y;
    logic [15:0] re, im, re_org, step_q;
    logic [7:0]  mi_q;
    logic        done_q;
    logic        last_px, x_end, done_rise, accept;

    // Q-format scaling only matters to the engine; re/im pass through as raw words.
    logic unused_frac;
    assign unused_frac = ^32'(FRAC);

    assign x_end     = (x == 10'(WIDTH - 1));
    assign last_px   = x_end && (y == 9'(HEIGHT - 1));
    assign done_rise = eng_done & ~done_q;
    assign accept    = pix_valid & pix_ready;

    assign eng_start    = (state == ISSUE);
    assign busy         = (state != IDLE);
    assign eng_x        = x;
    assign eng_y        = y;
    assign eng_re_c     = re;
    assign eng_im_c     = im;
    assign eng_max_iter = mi_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (frame_start) state_nxt = ISSUE;
            ISSUE:   state_nxt = WAIT;
            WAIT:    if (done_rise) state_nxt = OUTPUT;
            OUTPUT:  if (accept) state_nxt = last_px ? IDLE : ISSUE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            re         <= '0;
            im         <= '0;
            re_org     <= '0;
            step_q     <= '0;
            mi_q       <= '0;
            done_q     <= 1'b0;
            pix_valid  <= 1'b0;
            pix_x      <= '0;
            pix_y      <= '0;
            pix_depth  <= '0;
            pix_last   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_nxt;
            // Tracked every cycle so a done level left over from an earlier pixel never looks like an edge.
            done_q     <= eng_done;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        mi_q   <= max_iter;
                        re_org <= re_origin;
                        step_q <= step;
                        x      <= '0;
                        y      <= '0;
                        re     <= re_origin;
                        im     <= im_origin;
                    end
                end
                WAIT: begin
                    if (done_rise) begin
                        pix_x     <= x;
                        pix_y     <= y;
                        pix_depth <= eng_depth;
                        pix_last  <= last_px;
                        pix_valid <= 1'b1;
                    end
                end
                OUTPUT: begin
                    if (accept) begin
                        pix_valid <= 1'b0;
                        if (last_px) begin
                            frame_done <= 1'b1;
                        end else if (x_end) begin
                            x  <= '0;
                            re <= re_org;
                            y  <= y + 9'd1;
                            im <= im - step_q;
                        end else begin
                            x  <= x + 10'd1;
                            re <= re + step_q;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_pixel_dispatcher.sv
// tb/tb_pixel_dispatcher.sv - self-checking bench for pixel_dispatcher with a behavioural depth engine
module tb_pixel_dispatcher;
    localparam int W = 4;
    localparam int H = 2;
    localparam int NPIX = W * H;

    logic        sysclk = 1'b0;
    logic        reset_n = 1'b0;
    logic        frame_start = 1'b0;
    logic [7:0]  max_iter = '0;
    logic [15:0] re_origin = '0, im_origin = '0, step = '0;
    logic        eng_start;
    logic [9:0]  eng_x;
    logic [8:0]  eng_y;
    logic [15:0] eng_re_c, eng_im_c;
    logic [7:0]  eng_max_iter;
    logic        eng_done = 1'b0;
    logic [7:0]  eng_depth = '0;
    logic        pix_valid;
    logic        pix_ready = 1'b0;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [7:0]  pix_depth;
    logic        pix_last, busy, frame_done;

    pixel_dispatcher #(.FRAC(8), .WIDTH(W), .HEIGHT(H)) dut (
        .sysclk(sysclk), .reset_n(reset_n), .frame_start(frame_start),
        .max_iter(max_iter), .re_origin(re_origin), .im_origin(im_origin), .step(step),
        .eng_start(eng_start), .eng_x(eng_x), .eng_y(eng_y),
        .eng_re_c(eng_re_c), .eng_im_c(eng_im_c), .eng_max_iter(eng_max_iter),
        .eng_done(eng_done), .eng_depth(eng_depth),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_x(pix_x), .pix_y(pix_y),
        .pix_depth(pix_depth), .pix_last(pix_last), .busy(busy), .frame_done(frame_done)
    );

    always #5 sysclk = ~sysclk;

    int checks = 0;
    int errors = 0;

    // Reference model state: the latched view and progress through the frame.
    logic signed [15:0] cfg_ro, cfg_io, cfg_st;
    logic [7:0]  cfg_mi;
    int          issue_idx = 0, beat_idx = 0, frames_done = 0;
    logic [7:0]  dq[$];
    logic [15:0] cap_re30, cap_im30, cap_re01, cap_im01;
    logic [7:0]  cap_d10;

    int eng_lat = 3, eng_clr = 1, ready_mode = 0, bp_cnt = 0;
    bit force_en = 1'b0;

    typedef struct {
        logic [15:0] ro, io, st;
        logic [7:0]  mi;
        int          lat;
        logic [15:0] re30, im30, re01, im01;
    } vec_t;
    vec_t vecs[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] exp_re(input int n);
        return 16'(int'(cfg_ro) + (n % W) * int'(cfg_st));
    endfunction

    function automatic logic [15:0] exp_im(input int n);
        return 16'(int'(cfg_io) - (n / W) * int'(cfg_st));
    endfunction

    // Engine: depth chosen at start; stale done held eng_clr cycles, result raised after eng_lat cycles.
    initial begin : engine
        int cnt;
        bit pend;
        logic [7:0] d;
        cnt = 0; pend = 1'b0; d = '0;
        forever begin
            @(negedge sysclk);
            if (eng_start === 1'b1) begin
                pend = 1'b1;
                cnt = 0;
                if (force_en && eng_x == 10'd1 && eng_y == 9'd0) begin
                    d = 8'd7;
                    force_en = 1'b0;
                end else begin
                    d = 8'(eng_re_c[7:0] + eng_im_c[7:0] + eng_max_iter);
                end
                dq.push_back(d);
            end else if (pend) begin
                cnt++;
                if (cnt == eng_clr) eng_done = 1'b0;
                if (cnt == eng_lat) begin
                    eng_done = 1'b1;
                    eng_depth = d;
                    pend = 1'b0;
                end
            end
        end
    end

    initial begin : ready_drv
        forever begin
            @(posedge sysclk);
            #1;
            case (ready_mode)
                0: pix_ready = 1'b1;
                1: pix_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (pix_valid && pix_x == 10'd1 && pix_y == 9'd0 && bp_cnt < 5) begin
                        pix_ready = 1'b0;
                        bp_cnt++;
                    end else begin
                        pix_ready = 1'b1;
                    end
                end
            endcase
        end
    end

    initial begin : monitor
        bit hold, last_acc;
        logic [28:0] held;
        hold = 1'b0; last_acc = 1'b0; held = '0;
        forever begin
            @(negedge sysclk);
            if (reset_n) begin
                if (hold) chk("pix_stable", {pix_valid, pix_x, pix_y, pix_depth, pix_last}, held);
                if (eng_start) begin
                    chk("one_in_flight", pix_valid, 0);
                    chk("issue_count", 32'(issue_idx < NPIX), 1);
                    chk("issue_x", eng_x, issue_idx % W);
                    chk("issue_y", eng_y, issue_idx / W);
                    chk("issue_re", eng_re_c, exp_re(issue_idx));
                    chk("issue_im", eng_im_c, exp_im(issue_idx));
                    chk("issue_max_iter", eng_max_iter, cfg_mi);
                    if (issue_idx == 3) begin cap_re30 = eng_re_c; cap_im30 = eng_im_c; end
                    if (issue_idx == W) begin cap_re01 = eng_re_c; cap_im01 = eng_im_c; end
                    issue_idx++;
                end
                if (frame_done || last_acc) begin
                    chk("frame_done", frame_done, last_acc);
                    if (frame_done) begin
                        chk("beats_per_frame", beat_idx, NPIX);
                        frames_done++;
                    end
                end
                last_acc = 1'b0;
                if (pix_valid) begin
                    if (!hold) begin
                        chk("beat_x", pix_x, beat_idx % W);
                        chk("beat_y", pix_y, beat_idx / W);
                        chk("beat_last", pix_last, 32'(beat_idx == NPIX - 1));
                        if (dq.size() == 0) chk("beat_depth_queue", 0, 1);
                        else chk("beat_depth", pix_depth, dq[0]);
                        if (beat_idx == 1) cap_d10 = pix_depth;
                    end
                    if (pix_ready) begin
                        beat_idx++;
                        if (dq.size() > 0) void'(dq.pop_front());
                        last_acc = pix_last;
                        hold = 1'b0;
                    end else begin
                        hold = 1'b1;
                        held = {pix_valid, pix_x, pix_y, pix_depth, pix_last};
                    end
                end else begin
                    hold = 1'b0;
                end
            end else begin
                hold = 1'b0;
                last_acc = 1'b0;
            end
        end
    end

    task automatic start_frame(input logic [15:0] ro, io, st, input logic [7:0] mi);
        cfg_ro = ro; cfg_io = io; cfg_st = st; cfg_mi = mi;
        issue_idx = 0; beat_idx = 0;
        dq.delete();
        re_origin = ro; im_origin = io; step = st; max_iter = mi;
        frame_start = 1'b1;
        @(posedge sysclk);
        #1;
        frame_start = 1'b0;
        chk("busy_after_start", busy, 1);
        re_origin = 16'($urandom); im_origin = 16'($urandom);
        step = 16'($urandom); max_iter = 8'($urandom);
    endtask

    task automatic wait_frame(input string name);
        int target, n;
        target = frames_done + 1;
        n = 0;
        while (frames_done < target && n < 3000) begin
            @(posedge sysclk);
            n++;
        end
        #1;
        chk(name, 32'(frames_done >= target), 1);
        chk("idle_after_frame", busy, 0);
    endtask

    initial begin : main
        vecs[0] = '{16'hFE00, 16'd256, 16'd64, 8'd100, 3, 16'hFEC0, 16'd256, 16'hFE00, 16'd192};
        vecs[1] = '{16'h7FFF, 16'h8000, 16'd1, 8'd255, 2, 16'h8002, 16'h8000, 16'h7FFF, 16'h7FFF};
        vecs[2] = '{16'd100, 16'hFFCE, 16'hFFF6, 8'd0, 5, 16'd70, 16'hFFCE, 16'd100, 16'hFFD8};

        // Reset with frame_start held high throughout.
        reset_n = 1'b0;
        frame_start = 1'b1;
        repeat (2) @(posedge sysclk);
        @(negedge sysclk);
        chk("rst_ctrl", {eng_start, busy, frame_done, pix_valid, pix_last}, 0);
        chk("rst_eng_xy", {eng_x, eng_y}, 0);
        chk("rst_eng_c", {eng_re_c, eng_im_c}, 0);
        chk("rst_eng_mi", eng_max_iter, 0);
        chk("rst_pix", {pix_x, pix_y, pix_depth}, 0);
        @(posedge sysclk);
        #1;
        reset_n = 1'b1;
        frame_start = 1'b0;
        repeat (3) @(posedge sysclk);
        #1;
        chk("rst_no_frame", {busy, eng_start}, 0);

        for (int i = 0; i < 3; i++) begin
            eng_lat = vecs[i].lat;
            eng_clr = 1;
            ready_mode = 0;
            start_frame(vecs[i].ro, vecs[i].io, vecs[i].st, vecs[i].mi);
            wait_frame("table_frame_done");
            chk("table_re_3_0", cap_re30, vecs[i].re30);
            chk("table_im_3_0", cap_im30, vecs[i].im30);
            chk("table_re_0_1", cap_re01, vecs[i].re01);
            chk("table_im_0_1", cap_im01, vecs[i].im01);
        end

        // Stale done held from pixel (0,0) while (1,0) is in flight.
        eng_lat = 6; eng_clr = 3; force_en = 1'b1;
        start_frame(16'd0, 16'd0, 16'd16, 8'd200);
        wait_frame("stale_frame_done");
        chk("stale_done_depth", cap_d10, 7);

        // Backpressure on beat (1,0).
        eng_lat = 3; eng_clr = 1; ready_mode = 2; bp_cnt = 0;
        start_frame(16'd300, 16'hFF00, 16'd32, 8'd77);
        wait_frame("bp_frame_done");
        chk("bp_cycles", bp_cnt, 5);

        // frame_start mid-frame with a different view is ignored.
        ready_mode = 0;
        start_frame(16'd1000, 16'd2000, 16'd5, 8'd50);
        for (int n = 0; n < 500 && beat_idx < 3; n++) @(posedge sysclk);
        #1;
        re_origin = 16'hFFF9; im_origin = 16'd9; step = 16'd111; max_iter = 8'd3;
        frame_start = 1'b1;
        @(posedge sysclk);
        #1;
        frame_start = 1'b0;
        wait_frame("midstart_frame_done");

        // Reset while waiting on pixel 2; its late done arrives while idle.
        eng_lat = 6; eng_clr = 2;
        start_frame(16'd40, 16'd80, 16'd8, 8'd9);
        for (int n = 0; n < 500 && issue_idx < 3; n++) @(posedge sysclk);
        #1;
        reset_n = 1'b0;
        repeat (2) @(posedge sysclk);
        #1;
        reset_n = 1'b1;
        dq.delete();
        for (int n = 0; n < 10; n++) begin
            @(posedge sysclk);
            #1;
            chk("post_reset_quiet", {pix_valid, busy, frame_done}, 0);
        end
        start_frame(16'hF000, 16'd5, 16'd3, 8'd20);
        wait_frame("post_reset_frame_done");

        // Randomized frames with random engine timing and backpressure.
        ready_mode = 1;
        for (int f = 0; f < 6; f++) begin
            eng_lat = $urandom_range(2, 8);
            eng_clr = $urandom_range(1, eng_lat - 1);
            start_frame(16'($urandom), 16'($urandom), 16'($urandom), 8'($urandom));
            wait_frame("random_frame_done");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
